// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit 7-segment display sharing one BCD decoder.
// Optional build macro LEADING_ZERO_BLANK_EN: darkens digits above the most significant nonzero nibble.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] valor,
    output logic [3:0]              dec_in,
    input  logic [6:0]              dec_out,
    output logic [6:0]              SAIDA,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int VW   = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [VW-1:0]       display_q, display_d;
    logic [VW-1:0]       pending_q, pending_d;
    logic                pending_valid_q, pending_valid_d;
    logic [3:0]          dec_in_q, dec_in_d;
    logic [6:0]          saida_q, saida_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                frame_done_q, frame_done_d;
    logic [6:0]          showSeg;

    function automatic logic [3:0] nibbleAt(input logic [VW-1:0] v, input logic [IW-1:0] k);
        logic [VW-1:0] s;
        s = v >> {k, 2'b00};
        return s[3:0];
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k is blanked when it and every nibble above it are zero; digit 0 always shows.
    logic [NUM_DIGITS-1:0] lzMask;

    always_comb begin
        logic seenNz;
        seenNz = 1'b0;
        lzMask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (display_q[4*k +: 4] != 4'd0) begin
                seenNz = 1'b1;
            end
            lzMask[k] = !seenNz;
        end
    end

    assign showSeg = lzMask[idx_q] ? 7'd0 : dec_out;
`else
    assign showSeg = dec_out;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            cnt_q           <= '0;
            display_q       <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            dec_in_q        <= '0;
            saida_q         <= '0;
            digit_en_q      <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            display_q       <= display_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            dec_in_q        <= dec_in_d;
            saida_q         <= saida_d;
            digit_en_q      <= digit_en_d;
            frame_done_q    <= frame_done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        cnt_d           = cnt_q;
        display_d       = display_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        dec_in_d        = dec_in_q;
        saida_d         = saida_q;
        digit_en_d      = digit_en_q;
        frame_done_d    = 1'b0;

        if (load) begin
            pending_d       = valor;
            pending_valid_d = 1'b1;
        end

        if (!en) begin
            state_d    = IDLE;
            idx_d      = '0;
            cnt_d      = '0;
            saida_d    = '0;
            digit_en_d = '0;
            dec_in_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                    // A load arriving on this same edge stays pending for the next frame boundary.
                    if (pending_valid_q) begin
                        display_d       = pending_q;
                        pending_valid_d = load;
                    end
                    dec_in_d = nibbleAt(display_d, '0);
                end
                BLANK: begin
                    saida_d    = '0;
                    digit_en_d = '0;
                    if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                        state_d    = SHOW;
                        cnt_d      = '0;
                        saida_d    = showSeg;
                        digit_en_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                        state_d    = BLANK;
                        cnt_d      = '0;
                        saida_d    = '0;
                        digit_en_d = '0;
                        if (idx_q == IW'(NUM_DIGITS - 1)) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                            // Frame boundary: a coincident load bypasses the pending register.
                            if (load) begin
                                display_d       = valor;
                                pending_valid_d = 1'b0;
                            end else if (pending_valid_q) begin
                                display_d       = pending_q;
                                pending_valid_d = 1'b0;
                            end
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                        dec_in_d = nibbleAt(display_d, idx_d);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign dec_in     = dec_in_q;
    assign SAIDA      = saida_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a behavioural hex 7-segment decoder on dec_in/dec_out.
// Honours LEADING_ZERO_BLANK_EN when computing expected segment patterns.
module tb_display_scan_ctrl;

    localparam int ND     = 4;
    localparam int RD     = 4;
    localparam int BC     = 1;
    localparam int PERIOD = BC + RD;
    localparam int FRAME  = ND * PERIOD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] valor;
    logic [3:0]  dec_in;
    logic [6:0]  dec_out;
    logic [6:0]  SAIDA;
    logic [3:0]  digit_en;
    logic        frame_done;

    int totalChecks  = 0;
    int passedChecks = 0;

    typedef struct {
        string       name;
        logic [15:0] shown;
        int          loadAt;
        logic [15:0] loadVal;
        int          lastCycle;
    } frameVec_t;

    frameVec_t frames[5];

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .valor     (valor),
        .dec_in    (dec_in),
        .dec_out   (dec_out),
        .SAIDA     (SAIDA),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    function automatic logic [6:0] segOf(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    assign dec_out = segOf(dec_in);

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        logic [15:0] s;
        s = v >> (4 * d);
        return s[3:0];
    endfunction

    function automatic logic [6:0] expSeg(input logic [15:0] v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        logic [15:0] upper;
        upper = v >> (4 * d);
        if (d > 0 && upper == 16'd0) return 7'd0;
`endif
        return segOf(nib(v, d));
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic l, input logic [15:0] v);
        rst_n = r;
        en    = e;
        load  = l;
        valor = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkDark(input string name);
        checkOutput({name, " digit_en"}, 16'(digit_en), 16'd0);
        checkOutput({name, " SAIDA"}, 16'(SAIDA), 16'd0);
        checkOutput({name, " frame_done"}, 16'(frame_done), 16'd0);
    endtask

    // Cycle r counts edges after the IDLE->BLANK (or previous wrap) edge.
    task automatic runFrame(input string name, input logic [15:0] shown, input int loadAt,
                            input logic [15:0] loadVal, input int lastCycle);
        for (int r = 1; r <= lastCycle; r++) begin
            int c;
            int d;
            logic lit;
            if (r == loadAt) applyStimulus(1'b1, 1'b1, 1'b1, loadVal);
            step();
            load = 1'b0;
            c   = r % FRAME;
            d   = c / PERIOD;
            lit = (c % PERIOD) >= BC;
            checkOutput($sformatf("%s r%0d digit_en", name, r), 16'(digit_en),
                        lit ? 16'(4'b0001 << d) : 16'd0);
            checkOutput($sformatf("%s r%0d SAIDA", name, r), 16'(SAIDA),
                        lit ? 16'(expSeg(shown, d)) : 16'd0);
            checkOutput($sformatf("%s r%0d frame_done", name, r), 16'(frame_done),
                        16'(r == FRAME));
            if (r != FRAME) begin
                checkOutput($sformatf("%s r%0d dec_in", name, r), 16'(dec_in), 16'(nib(shown, d)));
            end
        end
    endtask

    initial begin
        frames[0] = '{"zeros",   16'h0000, 0,  16'h0000, FRAME};
        frames[1] = '{"s1234",   16'h1234, 0,  16'h0000, FRAME};
        frames[2] = '{"tear",    16'h1234, 12, 16'h9999, FRAME};
        frames[3] = '{"s9999",   16'h9999, 20, 16'h0007, FRAME};
        frames[4] = '{"s0007",   16'h0007, 0,  16'h0000, FRAME};

        // Reset dominates en and load.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF);
        step();
        step();
        checkDark("reset");
        checkOutput("reset dec_in", 16'(dec_in), 16'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        step();
        checkDark("idle");

        // Load and enable on the same edge: value waits for the first frame boundary.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234);
        step();
        load = 1'b0;
        checkDark("start");
        checkOutput("start dec_in", 16'(dec_in), 16'd0);

        for (int i = 0; i < 5; i++) begin
            runFrame(frames[i].name, frames[i].shown, frames[i].loadAt,
                     frames[i].loadVal, frames[i].lastCycle);
        end

        // Disable while digit 1 is lit, load during IDLE, then re-enable.
        runFrame("pre-dis", 16'h0007, 0, 16'h0000, 7);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        checkDark("dis0");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0042);
        step();
        checkDark("dis1");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        checkDark("dis2");
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        checkDark("reen");
        checkOutput("reen dec_in", 16'(dec_in), 16'h2);
        runFrame("s0042", 16'h0042, 5, 16'hABCD, FRAME);
        runFrame("sABCD", 16'hABCD, 0, 16'h0000, FRAME);
        runFrame("pre-rst", 16'hABCD, 0, 16'h0000, 8);

        // Reset mid-scan with a coincident load: the load must be dropped.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1111);
        step();
        checkDark("midrst");
        checkOutput("midrst dec_in", 16'(dec_in), 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        checkDark("post-rst");
        runFrame("post-rst", 16'h0000, 0, 16'h0000, FRAME);
        runFrame("post-rst2", 16'h0000, 0, 16'h0000, FRAME);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
